// File: rtl/sw_debounce_pkg.sv
// Board constants and shared defaults for the switch/button debouncer.
package sw_debounce_pkg;

  localparam int unsigned SYSCLK_HZ   = 125_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;

  // Stable cycles needed to accept a new level (10 ms at 125 MHz).
  localparam int unsigned DEBOUNCE_CYCLES_DEF = (SYSCLK_HZ / 1000) * DEBOUNCE_MS;

  // Board I/O widths.
  localparam int unsigned SW_WIDTH  = 4;
  localparam int unsigned LED_WIDTH = 4;

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_if.sv
// Raw switch inputs and conditioned level/edge outputs of the debouncer.
interface sw_debounce_if
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH = SW_WIDTH
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  // Board side: drives pins, consumes conditioned outputs.
  modport master (
    output sw_raw,
    input  sw_stable, sw_rise, sw_fall, sw_changed
  );

  // Debouncer side.
  modport slave (
    input  sw_raw,
    output sw_stable, sw_rise, sw_fall, sw_changed
  );

endinterface : sw_debounce_if

// File: rtl/sw_debounce_bit.sv
// One debounce channel: 2-flop synchroniser, stability counter, level and edge pulses.
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic toggle_c   // high in the cycle stable is about to change
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("debounce_bit: DEBOUNCE_CYCLES must be at least 2");
  end

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_d;

  // Next count/level: count while s2 disagrees, accept after DEBOUNCE_CYCLES in a row.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable;
    toggle_c = 1'b0;
    if (s2 != stable) begin
      if (cnt == CNT_LAST) begin
        stable_d = s2;
        toggle_c = 1'b1;
      end else begin
        cnt_d = cnt + CNT_W'(1);
      end
    end
  end

  // Synchroniser, counter, level and edge pulse registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      cnt    <= cnt_d;
      stable <= stable_d;
      rise   <= toggle_c & s2;
      fall   <= toggle_c & ~s2;
    end
  end

endmodule : debounce_bit

// File: rtl/sw_debounce.sv
// Debounces WIDTH raw switch inputs into clean levels plus rise/fall/changed pulses.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH           = SW_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic         sysclk,
  input  logic         rst_n,
  sw_debounce_if.slave sw
);

  logic [WIDTH-1:0] toggle;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .raw      (sw.sw_raw[i]),
      .stable   (sw.sw_stable[i]),
      .rise     (sw.sw_rise[i]),
      .fall     (sw.sw_fall[i]),
      .toggle_c (toggle[i])
    );
  end

  // Registered OR of all channel edges, aligned with the per-bit pulses.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sw.sw_changed <= 1'b0;
    end else begin
      sw.sw_changed <= |toggle;
    end
  end

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: window-based reference model, per-cycle monitor.
module tb_sw_debounce;

  localparam int unsigned W = 4;
  localparam int unsigned D = 8;

  typedef struct packed {
    logic [W-1:0] stable;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  sw_debounce_if #(.WIDTH(W)) sw_if ();

  sw_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .sysclk (clk),
    .rst_n  (rst_n),
    .sw     (sw_if)
  );

  always #5 clk = ~clk;

  exp_t         exp_q[$];
  logic [W-1:0] hist[$];     // raw samples, newest at index 0
  logic [W-1:0] m_stable;
  int           n_vec  = 0;
  int           n_fail = 0;
  int           cyc    = 0;

  // Reference model: a channel takes the synchronised value once the last D
  // synchronised samples (raw delayed by 2 edges) all disagree with its level.
  always @(posedge clk or negedge rst_n) begin
    exp_t         e;
    logic [W-1:0] flip;
    logic [W-1:0] h;
    if (!rst_n) begin
      m_stable = '0;
      hist.delete();
      for (int k = 0; k < D + 2; k++) hist.push_back('0);
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      hist.push_front(sw_if.sw_raw);
      flip = '0;
      for (int i = 0; i < W; i++) begin
        flip[i] = 1'b1;
        for (int j = 2; j < D + 2; j++) begin
          h = hist[j];
          if (h[i] == m_stable[i]) flip[i] = 1'b0;
        end
      end
      void'(hist.pop_back());
      m_stable  = m_stable ^ flip;
      e.stable  = m_stable;
      e.rise    = flip & m_stable;
      e.fall    = flip & ~m_stable;
      e.changed = |flip;
      exp_q.push_back(e);
    end
  end

  // Monitor: the DUT presents outputs every cycle; compare against the model.
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    cyc++;
    got = {sw_if.sw_stable, sw_if.sw_rise, sw_if.sw_fall, sw_if.sw_changed};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL no_expectation cyc=%0d got=%h", cyc, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got stable=%b rise=%b fall=%b chg=%b exp stable=%b rise=%b fall=%b chg=%b",
                 cyc, got.stable, got.rise, got.fall, got.changed,
                 e.stable, e.rise, e.fall, e.changed);
      end
    end
  end

  // Hold raw/reset values for n cycles, changing just after a rising edge.
  task automatic apply(input logic [W-1:0] raw, input logic rst, input int n);
    sw_if.sw_raw = raw;
    rst_n        = rst;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    logic [W-1:0] r;
    int           hold[W];
    rst_n        = 1'b0;
    sw_if.sw_raw = '0;
    @(posedge clk);
    #2;

    // Toggle inputs under reset, then release with inputs low.
    apply(4'b0101, 1'b0, 3);
    apply(4'b1010, 1'b0, 3);
    apply(4'b0000, 1'b0, 2);
    apply(4'b0000, 1'b1, 50);
    // Clean step on channel 0.
    apply(4'b0001, 1'b1, 20);
    // Bounce train on channel 1.
    apply(4'b0011, 1'b1, 3);
    apply(4'b0001, 1'b1, 2);
    apply(4'b0011, 1'b1, 20);
    // Short glitch on channel 2.
    apply(4'b0111, 1'b1, 5);
    apply(4'b0011, 1'b1, 20);
    // Simultaneous edges.
    apply(4'b0000, 1'b1, 20);
    apply(4'b1011, 1'b1, 20);
    apply(4'b0001, 1'b1, 20);
    // Reset mid-count, input held high through release.
    apply(4'b1001, 1'b1, 5);
    apply(4'b1001, 1'b0, 3);
    apply(4'b1001, 1'b1, 20);

    // Random bounce trains of mixed lengths, occasional resets.
    r = 4'b1001;
    for (int i = 0; i < W; i++) hold[i] = $urandom_range(1, 14);
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          r[i]    = ~r[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 30) : $urandom_range(1, 10);
        end else begin
          hold[i]--;
        end
      end
      if ($urandom_range(0, 299) == 0) apply(r, 1'b0, $urandom_range(1, 3));
      else apply(r, 1'b1, 1);
    end
    apply(r, 1'b1, 15);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_sw_debounce
